// File: rtl/bitbrick_seq_ctrl.sv
// Sequencing controller for a bitbrick multiplier array.
// It takes one operand set at a time and walks every 2-bit slice pair
// (i inner, j outer) through an external bitbrick multiplier and shifter.
// The shifted partial products are summed into an accumulator, and the
// final product is held until the consumer accepts it.
module bitbrick_seq_ctrl #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [1:0]       prec_a,
    input  logic [1:0]       prec_b,
    input  logic             sign_a,
    input  logic             sign_b,
    output logic [1:0]       brick_a,
    output logic [1:0]       brick_b,
    output logic             brick_sa,
    output logic             brick_sb,
    output logic [2:0]       shift_sig,
    output logic             brick_valid,
    input  logic [15:0]      shifted_prod,
    output logic [ACC_W-1:0] result,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [1:0]              i_idx;
    logic [1:0]              j_idx;
    logic signed [ACC_W-1:0] acc;
    logic                    in_ready_q;
    logic                    out_valid_q;

    // Operands captured on the accepting edge; the last slice index stands in
    // for the precision so the loop compares against it directly.
    logic [7:0]              a_q;
    logic [7:0]              b_q;
    logic [1:0]              last_a;
    logic [1:0]              last_b;
    logic                    sa_q;
    logic                    sb_q;

    logic                    accept;
    logic                    running;

    // Index of the most significant 2-bit slice for a precision code.
    function automatic logic [1:0] last_slice(input logic [1:0] prec);
        case (prec)
            2'b00:   last_slice = 2'd0;
            2'b01:   last_slice = 2'd1;
            default: last_slice = 2'd3;
        endcase
    endfunction

    // Accumulate a 16-bit signed partial product, wrapping modulo 2^ACC_W.
    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] cur,
        input logic        [15:0]      prod
    );
        logic signed [15:0]      prod_s;
        logic signed [ACC_W-1:0] prod_ext;
        prod_s   = prod;
        prod_ext = ACC_W'(prod_s);
        acc_add  = cur + prod_ext;
    endfunction

    assign accept  = (state == IDLE) && in_ready_q && in_valid;
    assign running = (state == RUN);

    // Latch the operand set on the accepting edge; held unchanged otherwise.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q    <= a;
            b_q    <= b;
            last_a <= last_slice(prec_a);
            last_b <= last_slice(prec_b);
            sa_q   <= sign_a;
            sb_q   <= sign_b;
        end
    end

    // Control FSM: slice-pair walk, accumulation and result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            i_idx       <= 2'd0;
            j_idx       <= 2'd0;
            acc         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= RUN;
                        acc        <= '0;
                        i_idx      <= 2'd0;
                        j_idx      <= 2'd0;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_add(acc, shifted_prod);
                    if (i_idx == last_a) begin
                        i_idx <= 2'd0;
                        if (j_idx == last_b) begin
                            j_idx       <= 2'd0;
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            j_idx <= j_idx + 2'd1;
                        end
                    end else begin
                        i_idx <= i_idx + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    // Slice outputs are decoded from registered state and forced to zero outside RUN.
    always_comb begin
        brick_valid = running;
        brick_a     = 2'd0;
        brick_b     = 2'd0;
        brick_sa    = 1'b0;
        brick_sb    = 1'b0;
        shift_sig   = 3'd0;
        if (running) begin
            brick_a   = a_q[{i_idx, 1'b0} +: 2];
            brick_b   = b_q[{j_idx, 1'b0} +: 2];
            brick_sa  = sa_q && (i_idx == last_a);
            brick_sb  = sb_q && (j_idx == last_b);
            shift_sig = {1'b0, i_idx} + {1'b0, j_idx};
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = out_valid_q ? acc : '0;

endmodule

// File: doc/bitbrick_seq_ctrl.md
BITBRICK_SEQ_CTRL -- requirements
Module: bitbrick_seq_ctrl

Interface
REQ-001 Parameter: ACC_W, default 16, accumulator/result width; legal values are 16 or greater.
REQ-002 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand set offered.
REQ-005 Port: in_ready  output  1  controller can accept an operand set.
REQ-006 Port: a, b  input  8 each  multiplicand/multiplier; only the low 2/4/8 bits are used, per precision.
REQ-007 Port: prec_a, prec_b  input  2 each  00=2-bit, 01=4-bit, 10=8-bit, 11=8-bit.
REQ-008 Port: sign_a, sign_b  input  1 each  1 = operand is two's complement, 0 = unsigned.
REQ-009 Port: brick_a, brick_b  output  2 each  current 2-bit operand slices to the external bitbrick multiplier.
REQ-010 Port: brick_sa, brick_sb  output  1 each  signed flag for each current slice.
REQ-011 Port: shift_sig  output  3  shift control to the external bitbrick shifter; shift = 2*shift_sig bits.
REQ-012 Port: brick_valid  output  1  brick_*/shift_sig are meaningful this cycle.
REQ-013 Port: shifted_prod  input  16  combinational shifter result for the current brick pair, same cycle.
REQ-014 Port: result  output  ACC_W  final product.
REQ-015 Port: out_valid  output  1  result is valid.
REQ-016 Port: out_ready  input  1  consumer accepts result.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 In IDLE, in_ready SHALL be 1; at any other time it SHALL be 0.
REQ-019 On an IDLE edge with in_valid=1, the controller SHALL latch a, b, prec_*, sign_*, clear the accumulator and indices i and j to 0, and go to RUN.
REQ-020 Brick counts: na = 1, 2 or 4 for prec_a = 00, 01 or 1x respectively; nb is derived from prec_b the same way.
REQ-021 In RUN, the slice outputs SHALL be driven as follows:
- brick_valid=1;
- brick_a = a[2i+1:2i] and brick_b = b[2j+1:2j];
- brick_sa = sign_a AND (i == na-1);
- brick_sb = sign_b AND (j == nb-1);
- shift_sig = i + j (range 0..6).
REQ-022 On each RUN edge, the accumulator SHALL be updated to acc + sign-extended shifted_prod, with modulo 2^ACC_W wrap-around.
REQ-023 Iteration order SHALL be i inner and j outer: i increments, and at i = na-1, i returns to 0 and j increments.
REQ-024 After the pair (na-1, nb-1) is accumulated, the FSM SHALL go to DONE; RUN lasts exactly na*nb cycles (1 to 16).
REQ-025 In DONE, out_valid=1 and result = accumulator, both held stable until out_ready=1.
REQ-026 The edge in DONE with out_ready=1 SHALL return the FSM to IDLE; the next input is accepted no earlier than the following edge.
REQ-027 Latency from the accepting edge to out_valid rising SHALL be na*nb cycles.
REQ-028 result SHALL equal the exact product of the latched operands; an 8x8 signed or unsigned product fits in 16 bits.
REQ-029 in_valid and operand changes during RUN or DONE SHALL be ignored.
REQ-030 Outside RUN, brick_valid SHALL be 0 and brick_a, brick_b, brick_sa, brick_sb and shift_sig SHALL be 0.

Reset
REQ-031 When rst_n=0, the controller SHALL immediately, without waiting for a clock edge, enter IDLE with accumulator=0, i=j=0, out_valid=0 and brick_valid=0; in_ready=1 takes effect on the first edge after rst_n deasserts.
REQ-032 Reset asserted mid-RUN or in DONE SHALL abandon the operation, and no stale result SHALL appear after reset.

Verification
REQ-033 Case 8b x 8b signed: a=0x80, b=0x80, with an ideal bitbrick model -> 16 RUN cycles, shift_sig sequence 0,1,2,3,1,2,3,4,2,...,6, and result=16384.
REQ-034 Case 2b x 2b signed: a=0x2 (-2), b=0x3 (-1) -> one RUN cycle with brick_sa=brick_sb=1, result=2, and out_valid on the 2nd edge.
REQ-035 Case 4b x 4b unsigned: 15 x 15 -> 4 RUN cycles and result=225; mixed case 8b signed x 2b unsigned, -5 x 3 -> 4 RUN cycles and result=0xFFF1.
REQ-036 Case backpressure: hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable and in_ready=0; then out_ready=1 -> IDLE on the next edge.
REQ-037 Case reset: assert rst_n=0 at RUN cycle 3 of an 8x8 job -> outputs at reset values immediately; a new 2x2 job afterward returns the correct result with no carry-over.
REQ-038 Case overlap: in_valid held high continuously with changing operands -> each job uses the operands from its accepting edge only, and jobs never overlap.
